lab3_g8_scan: RTL and testbench



---
 rtl/lab3_g8_pkg.sv | 25 ++
 rtl/lab3_g8_tick_gen.sv | 38 +++
 rtl/lab3_g8_scan.sv | 140 ++++++++++++++
 tb/tb_lab3_g8_scan.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lab3_g8_pkg.sv
// ============================================================================
// Module   : lab3_g8_pkg
// Purpose  : Shared types and constants for the lab3_g8 seven-segment scanner.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package lab3_g8_pkg;

  localparam int MAX_DIGITS = 8;

  typedef logic [3:0] nibble_t;

  // Digit enables are active low, so all-ones turns every digit off.
  localparam logic [MAX_DIGITS-1:0] c_digits_off = '1;

  function automatic nibble_t get_nibble(input logic [4*MAX_DIGITS-1:0] frame,
                                         input int unsigned             pos);
    return frame[4*pos +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/lab3_g8_tick_gen.sv
// ============================================================================
// Module   : lab3_g8_tick_gen
// Purpose  : Refresh-slot prescaler; counts 0..REFRESH_DIV-1 and flags the last cycle.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lab3_g8_tick_gen #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_tick = (r_cnt == c_cnt_last);

endmodule

`default_nettype wire

// File: rtl/lab3_g8_scan.sv
// ============================================================================
// Module   : lab3_g8_scan
// Purpose  : Multiplexed seven-segment scan controller with frame-aligned,
//            double-buffered display data. Optional: LEAD_ZERO_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lab3_g8_scan
  import lab3_g8_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output nibble_t                 x,
  output logic [NUM_DIGITS-1:0]   digit_an_n,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int c_cnt_w  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_idx_w  = $clog2(NUM_DIGITS);
  localparam int c_data_w = 4 * NUM_DIGITS;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

  logic [c_cnt_w-1:0]    w_cnt;
  logic                  w_tick;
  logic [c_cnt_w-1:0]    w_cnt_nxt;
  logic [c_idx_w-1:0]    w_idx_nxt;
  logic                  w_commit;
  logic [c_data_w-1:0]   w_active_nxt;
  logic                  w_lit;
  logic                  w_fd_nxt;
  nibble_t               w_x_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  logic [c_idx_w-1:0]    r_idx;
  logic [c_data_w-1:0]   r_shadow;
  logic [c_data_w-1:0]   r_active;
  logic                  r_pending;
  logic                  r_frame_done;
  nibble_t               r_x;
  logic [NUM_DIGITS-1:0] r_an_n;

  lab3_g8_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (c_cnt_w)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_cnt  (w_cnt),
    .o_tick (w_tick)
  );

  // Outputs are registered from next-state values so they line up with cnt/idx.
  assign w_cnt_nxt    = w_tick ? '0 : c_cnt_w'(w_cnt + 1'b1);
  assign w_idx_nxt    = !w_tick ? r_idx :
                        (r_idx == c_idx_last) ? '0 : c_idx_w'(r_idx + 1'b1);
  assign w_commit     = w_tick && (r_idx == c_idx_last);
  assign w_active_nxt = (w_commit && r_pending) ? r_shadow : r_active;
  assign w_fd_nxt     = (w_cnt_nxt == c_cnt_last) && (w_idx_nxt == c_idx_last);
  assign w_x_nxt      = get_nibble((4*MAX_DIGITS)'(w_active_nxt), 32'(w_idx_nxt));

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_lit = 1'b1;
    end else begin : g_blank
      localparam logic [c_cnt_w-1:0] c_blank = c_cnt_w'(BLANK_CYCLES);
      assign w_lit = (w_cnt_nxt >= c_blank);
    end
  endgenerate

`ifdef LEAD_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz_mask;

  // Digit i>0 is suppressed when it and every more significant digit are zero.
  always_comb begin
    logic v_nonzero;
    v_nonzero = 1'b0;
    w_lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      v_nonzero    = v_nonzero | (|w_active_nxt[4*i +: 4]);
      w_lz_mask[i] = ~v_nonzero;
    end
  end
`endif

  always_comb begin
    w_an_nxt = c_digits_off[NUM_DIGITS-1:0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_lit && (w_idx_nxt == c_idx_w'(i))) begin
        w_an_nxt[i] = 1'b0;
      end
    end
`ifdef LEAD_ZERO_BLANK_EN
    w_an_nxt = w_an_nxt | w_lz_mask;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_x          <= '0;
      r_an_n       <= c_digits_off[NUM_DIGITS-1:0];
    end else begin
      r_idx        <= w_idx_nxt;
      r_active     <= w_active_nxt;
      r_frame_done <= w_fd_nxt;
      r_x          <= w_x_nxt;
      r_an_n       <= w_an_nxt;
      // A load coinciding with a commit lands in shadow and stays pending.
      if (load) begin
        r_shadow  <= data_in;
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign x          = r_x;
  assign digit_an_n = r_an_n;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_lab3_g8_scan.sv
// ============================================================================
// Module   : tb_lab3_g8_scan
// Purpose  : Self-checking bench for lab3_g8_scan against a time-based model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lab3_g8_scan;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BL = 1;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        load    = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  x;
  logic [3:0]  digit_an_n;
  logic        pending;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: m_t counts cycles since reset release; slot/digit follow by division.
  int          m_t       = 0;
  logic [15:0] m_shadow  = 16'h0;
  logic [15:0] m_active  = 16'h0;
  bit          m_pending = 1'b0;

  always #5 clk = ~clk;

  lab3_g8_scan #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .x          (x),
    .digit_an_n (digit_an_n),
    .pending    (pending),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (t=%0d): got 0x%0h expected 0x%0h", tag, m_t, got, exp);
  endtask

  function automatic int m_idx();
    return (m_t / RD) % N;
  endfunction

  function automatic int m_pos();
    return m_t % RD;
  endfunction

  function automatic bit m_fd();
    return (m_pos() == RD - 1) && (m_idx() == N - 1);
  endfunction

  function automatic logic [3:0] m_x();
    return 4'((m_active >> (4 * m_idx())) & 16'hF);
  endfunction

  function automatic logic [3:0] m_an();
    logic [3:0] an = 4'hF;
    int k = m_idx();
    bit show = (m_pos() >= BL);
`ifdef LEAD_ZERO_BLANK_EN
    if (k > 0 && (m_active >> (4 * k)) == 16'h0) show = 1'b0;
`endif
    if (show) an[k] = 1'b0;
    return an;
  endfunction

  task automatic run_cycle(input logic ld, input logic [15:0] d);
    load    = ld;
    data_in = d;
    chk("x", 32'(x), 32'(m_x()));
    chk("digit_an_n", 32'(digit_an_n), 32'(m_an()));
    chk("pending", 32'(pending), 32'(m_pending));
    chk("frame_done", 32'(frame_done), 32'(m_fd()));
    @(posedge clk);
    if (m_fd()) begin
      if (m_pending) m_active = m_shadow;
      m_pending = 1'b0;
    end
    if (ld) begin
      m_shadow  = d;
      m_pending = 1'b1;
    end
    m_t++;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_x"}, 32'(x), 32'h0);
    chk({tag, "_an"}, 32'(digit_an_n), 32'hF);
    chk({tag, "_pending"}, 32'(pending), 32'h0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Called at a falling edge; asserts reset mid-cycle, releases on a later falling edge.
  task automatic do_reset(input int hold);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("rst_async");
    repeat (hold) @(posedge clk);
    @(negedge clk);
    chk_reset_values("rst_hold");
    rst_n     = 1'b1;
    m_t       = 0;
    m_active  = 16'h0;
    m_shadow  = 16'h0;
    m_pending = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;

    @(negedge clk);
    do_reset(2);

    // First frame_done pulse: count cycles after release, inclusive of the pulse.
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc++;
      if (frame_done === 1'b1) seen = 1'b1;
      run_cycle(1'b0, 16'h0);
    end
    chk("first_fd_cycles", seen ? 32'(cyc) : 32'h0, 32'd16);

    run_cycle(1'b1, 16'h1234);
    chk("pending_after_load", 32'(pending), 32'h1);
    repeat (40) run_cycle(1'b0, 16'h0);

    // Load in the commit cycle: old shadow is shown, new data stays pending.
    run_cycle(1'b1, 16'h1234);
    for (int i = 0; i < 20 && !m_fd(); i++) run_cycle(1'b0, 16'h0);
    run_cycle(1'b1, 16'hABCD);
    chk("pending_after_commit_load", 32'(pending), 32'h1);
    chk("x_after_commit_load", 32'(x), 32'h4);
    repeat (40) run_cycle(1'b0, 16'h0);

    for (int i = 0; i < 20 && !(m_idx() == 2 && m_pos() == 1); i++) run_cycle(1'b0, 16'h0);
    do_reset(1);
    repeat (20) run_cycle(1'b0, 16'h0);

    run_cycle(1'b1, 16'h0005);
    repeat (40) run_cycle(1'b0, 16'h0);

    repeat (400) run_cycle(($urandom_range(0, 5) == 0), 16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
